// File: rtl/qe_wiz_bus_timer.sv
// -----------------------------------------------------------------------------
// qe_wiz_bus_timer
//
// Sequences a decoded W5300 access from the QL 68008 bus into timed W5300 bus
// strobes. The access runs through setup, strobe, hold and recovery phases.
// The lengths of these phases are set by parameters.
// DTACK is requested only after the W5300 access time has been met.
// A CPU cycle that ends early (wiz_sel dropped before dtack_req) is reported
// with a one-cycle abort pulse.
//
// Parameters
//   SETUP_CYC    clk cycles of CS low before RD/WR falls            (1..15)
//   STROBE_CYC   minimum clk cycles of RD/WR low before dtack_req     (1..15)
//   HOLD_CYC     clk cycles of CS low after RD/WR rises               (1..15)
//   RECOVER_CYC  clk cycles of CS high before the next access starts  (1..15)
//
// Ports
//   clk        in   card clock
//   reset      in   synchronous, active-high reset
//   wiz_sel    in   asynchronous; high = W5300 decoded with AS and DS asserted
//   rdwl       in   68008 R/W (1 = read), captured at the start of an access
//   wizcsl     out  W5300 chip select, active low, registered
//   wizrdl     out  W5300 read strobe, active low, registered
//   wizwrl     out  W5300 write strobe, active low, registered
//   dtack_req  out  request to the open-drain DTACK driver, registered
//   busy       out  high whenever the sequencer is not idle, registered
//   abort      out  one-cycle pulse when wiz_sel drops before dtack_req
// -----------------------------------------------------------------------------
module qe_wiz_bus_timer #(
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned STROBE_CYC  = 3,
   parameter int unsigned HOLD_CYC    = 1,
   parameter int unsigned RECOVER_CYC = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic wiz_sel,
   input  logic rdwl,
   output logic wizcsl,
   output logic wizrdl,
   output logic wizwrl,
   output logic dtack_req,
   output logic busy,
   output logic abort
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      ACK     = 3'd3,
      HOLD    = 3'd4,
      RECOVER = 3'd5
   } state_t;

   // The phase counter is loaded with N-1 when a phase is entered.
   // The phase then lasts exactly N cycles.
   localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_nxt_s;
   logic       cnt_zero_s;
   logic       sync_meta_r;
   logic       sel_s;          // synchronised wiz_sel (second flop)
   logic       rd_r;           // R/W captured at IDLE->SETUP
   logic       rd_nxt_s;
   logic       abort_nxt_s;
   logic       csl_nxt_s;
   logic       rdl_nxt_s;
   logic       wrl_nxt_s;
   logic       dtack_nxt_s;
   logic       busy_nxt_s;

   assign cnt_zero_s = (cnt_r == 4'd0);

   // Phase sequencing: next state, counter reload/decrement, abort detection
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rd_nxt_s    = rd_r;
      abort_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (sel_s) begin
               state_nxt_s = SETUP;
               cnt_nxt_s   = SETUP_LD;
               rd_nxt_s    = rdwl;
            end else begin
               cnt_nxt_s   = 4'd0;
            end
         end
         SETUP: begin
            // wiz_sel is checked only when setup expires.
            // A drop seen then still goes through HOLD so that CS is deasserted cleanly.
            if (cnt_zero_s) begin
               if (sel_s) begin
                  state_nxt_s = STROBE;
                  cnt_nxt_s   = STROBE_LD;
               end else begin
                  state_nxt_s = HOLD;
                  cnt_nxt_s   = HOLD_LD;
                  abort_nxt_s = 1'b1;
               end
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         STROBE: begin
            // A CPU cycle ending mid-strobe takes priority over expiry.
            // This makes sure DTACK is never raised for an access the CPU has already left.
            if (!sel_s) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = HOLD_LD;
               abort_nxt_s = 1'b1;
            end else if (cnt_zero_s) begin
               state_nxt_s = ACK;
               cnt_nxt_s   = 4'd0;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ACK: begin
            if (!sel_s) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = HOLD_LD;
            end else begin
               cnt_nxt_s   = 4'd0;
            end
         end
         HOLD: begin
            if (cnt_zero_s) begin
               state_nxt_s = RECOVER;
               cnt_nxt_s   = RECOVER_LD;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         RECOVER: begin
            // sel_s is deliberately ignored here; the full recovery is always served
            if (cnt_zero_s) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 4'd0;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // Output decode from the state about to be entered.
   // The registered outputs then match the new state on the same edge.
   always_comb begin
      csl_nxt_s   = 1'b1;
      rdl_nxt_s   = 1'b1;
      wrl_nxt_s   = 1'b1;
      dtack_nxt_s = 1'b0;
      busy_nxt_s  = (state_nxt_s != IDLE);
      case (state_nxt_s)
         SETUP, HOLD: begin
            csl_nxt_s = 1'b0;
         end
         STROBE: begin
            csl_nxt_s = 1'b0;
            rdl_nxt_s = ~rd_nxt_s;
            wrl_nxt_s = rd_nxt_s;
         end
         ACK: begin
            csl_nxt_s   = 1'b0;
            rdl_nxt_s   = ~rd_nxt_s;
            wrl_nxt_s   = rd_nxt_s;
            dtack_nxt_s = 1'b1;
         end
         default: begin
            csl_nxt_s = 1'b1;
         end
      endcase
   end

   // State, counter, synchroniser and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         sync_meta_r <= 1'b0;
         sel_s       <= 1'b0;
         rd_r        <= 1'b0;
         wizcsl      <= 1'b1;
         wizrdl      <= 1'b1;
         wizwrl      <= 1'b1;
         dtack_req   <= 1'b0;
         busy        <= 1'b0;
         abort       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         sync_meta_r <= wiz_sel;
         sel_s       <= sync_meta_r;
         rd_r        <= rd_nxt_s;
         wizcsl      <= csl_nxt_s;
         wizrdl      <= rdl_nxt_s;
         wizwrl      <= wrl_nxt_s;
         dtack_req   <= dtack_nxt_s;
         busy        <= busy_nxt_s;
         abort       <= abort_nxt_s;
      end
   end

endmodule

// File: tb/tb_qe_wiz_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_qe_wiz_bus_timer
//
// Two instances of qe_wiz_bus_timer are tested: one with default timing and
// one with SETUP=2, STROBE=5, HOLD=3.
// For each access, the stimulus works out from the timing rules the cycle of
// every output transition. It then queues these transitions as expected events.
// A monitor runs on the falling clock edge. It turns observed output transitions
// into events and compares them with the queue. It also checks the strobe
// invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_qe_wiz_bus_timer;

   localparam int S0 = 1, T0 = 3, H0 = 1, R0 = 2;
   localparam int S1 = 2, T1 = 5, H1 = 3, R1 = 2;

   logic clk = 1'b0;
   logic reset;
   logic wiz_sel0, rdwl0, wiz_sel1, rdwl1;
   logic csl0, rdl0, wrl0, dtack0, busy0, abort0;
   logic csl1, rdl1, wrl1, dtack1, busy1, abort1;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   expq[2][$];
   int   free_at[2];
   int   last_ev = 0;
   bit   mon_en = 1'b0;
   logic [5:0] prev[2];
   logic [5:0] mon_cur;
   int   mon_key;
   int   mon_exp;

   qe_wiz_bus_timer u_dut0 (
      .clk(clk), .reset(reset), .wiz_sel(wiz_sel0), .rdwl(rdwl0),
      .wizcsl(csl0), .wizrdl(rdl0), .wizwrl(wrl0),
      .dtack_req(dtack0), .busy(busy0), .abort(abort0)
   );

   qe_wiz_bus_timer #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1), .RECOVER_CYC(R1)) u_dut1 (
      .clk(clk), .reset(reset), .wiz_sel(wiz_sel1), .rdwl(rdwl1),
      .wizcsl(csl1), .wizrdl(rdl1), .wizwrl(wrl1),
      .dtack_req(dtack1), .busy(busy1), .abort(abort1)
   );

   always #5 clk = ~clk;

   // edge counter: after posedge number k, cyc == k
   always @(posedge clk) cyc <= cyc + 1;

   // event key: cycle, signal id (0 csl,1 rd,2 wr,3 dtack,4 busy,5 abort), new value
   function automatic int key(input int c, input int sig, input int v);
      return c * 16 + sig * 2 + v;
   endfunction

   function automatic string sname(input int sig);
      case (sig)
         0: return "wizcsl";
         1: return "wizrdl";
         2: return "wizwrl";
         3: return "dtack_req";
         4: return "busy";
         5: return "abort";
         default: return "?";
      endcase
   endfunction

   function automatic int prm(input int i, input int which);
      int p[4];
      if (i == 0) begin p[0] = S0; p[1] = T0; p[2] = H0; p[3] = R0; end
      else        begin p[0] = S1; p[1] = T1; p[2] = H1; p[3] = R1; end
      return p[which];
   endfunction

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input int i, input logic sel, input logic rd);
      if (i == 0) begin wiz_sel0 = sel; rdwl0 = rd; end
      else        begin wiz_sel1 = sel; rdwl1 = rd; end
   endtask

   task automatic set_rd(input int i, input logic rd);
      if (i == 0) rdwl0 = rd;
      else        rdwl1 = rd;
   endtask

   task automatic set_sel(input int i, input logic sel);
      if (i == 0) wiz_sel0 = sel;
      else        wiz_sel1 = sel;
   endtask

   // One access on DUT i. wiz_sel rises after edge e.
   // ab=0: a normal access; wiz_sel drops sel cycles later than the earliest
   //       legal drop after ACK entry.
   // ab=1: an aborted access; wiz_sel drops so that the FSM sees it sel+1 edges
   //       after CS falls.
   // Returns f, the edge after which wiz_sel was dropped.
   task automatic access(input int i, input int e, input bit is_rd, input bit ab,
                         input int sel, output int f);
      int s, t, h, r, cs, rdf, dt, a, hs, idle, sid;
      int q[$];
      s = prm(i, 0); t = prm(i, 1); h = prm(i, 2); r = prm(i, 3);
      cs = e + 3;
      if (free_at[i] > cs) cs = free_at[i];
      rdf = cs + s;
      dt  = rdf + t;
      sid = is_rd ? 1 : 2;
      q.push_back(key(cs, 0, 0));
      q.push_back(key(cs, 4, 1));
      if (!ab) begin
         f  = dt - 2 + sel;
         hs = f + 3;
         q.push_back(key(rdf, sid, 0));
         q.push_back(key(dt, 3, 1));
         q.push_back(key(hs, sid, 1));
         q.push_back(key(hs, 3, 0));
      end else begin
         f = cs - 2 + sel;
         if (f + 3 <= rdf) begin
            a = rdf;
         end else begin
            a = f + 3;
            q.push_back(key(rdf, sid, 0));
            q.push_back(key(a, sid, 1));
         end
         q.push_back(key(a, 5, 1));
         q.push_back(key(a + 1, 5, 0));
         hs = a;
      end
      q.push_back(key(hs + h, 0, 1));
      idle = hs + h + r;
      q.push_back(key(idle, 4, 0));
      free_at[i] = idle + 1;
      if (idle + 1 > last_ev) last_ev = idle + 1;
      q.sort();
      foreach (q[k]) expq[i].push_back(q[k]);
      goto(e);
      set_in(i, 1'b1, is_rd);
      for (int c = e + 1; c <= f; c++) begin
         goto(c);
         if (c == f) set_sel(i, 1'b0);
         else if (c >= cs) set_rd(i, logic'($urandom_range(0, 1)));
      end
   endtask

   // Monitor: invariants plus event comparison against the expected queues
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            mon_cur = (i == 0) ? {abort0, busy0, dtack0, wrl0, rdl0, csl0}
                               : {abort1, busy1, dtack1, wrl1, rdl1, csl1};
            checks++;
            if (mon_cur[1] == 1'b0 && mon_cur[2] == 1'b0) begin
               errors++;
               $display("FAIL excl dut%0d cyc %0d: wizrdl=0 wizwrl=0, required not both 0", i, cyc);
            end
            checks++;
            if ((mon_cur[1] == 1'b0 || mon_cur[2] == 1'b0) && mon_cur[0] == 1'b1) begin
               errors++;
               $display("FAIL strobe_cs dut%0d cyc %0d: RD/WR low with wizcsl=1, required wizcsl=0", i, cyc);
            end
            while (expq[i].size() > 0 && (expq[i][0] / 16) < cyc) begin
               mon_exp = expq[i].pop_front();
               checks++;
               errors++;
               $display("FAIL missed dut%0d: no %s=%0d seen, required at cyc %0d",
                        i, sname((mon_exp / 2) % 8), mon_exp % 2, mon_exp / 16);
            end
            for (int b = 0; b < 6; b++) begin
               if (mon_cur[b] != prev[i][b]) begin
                  mon_key = key(cyc, b, int'(mon_cur[b]));
                  checks++;
                  if (expq[i].size() == 0) begin
                     errors++;
                     $display("FAIL unexpected dut%0d: %s=%0d at cyc %0d, required no change",
                              i, sname(b), mon_cur[b], cyc);
                  end else begin
                     mon_exp = expq[i].pop_front();
                     if (mon_exp != mon_key) begin
                        errors++;
                        $display("FAIL event dut%0d: got %s=%0d at cyc %0d, required %s=%0d at cyc %0d",
                                 i, sname(b), mon_cur[b], cyc,
                                 sname((mon_exp / 2) % 8), mon_exp % 2, mon_exp / 16);
                     end
                  end
               end
            end
            prev[i] = mon_cur;
         end
      end
   end

   initial begin
      int f, e, gap;
      bit ab, rd;
      reset = 1'b1;
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0);
      free_at[0] = 0;
      free_at[1] = 0;
      goto(3);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({abort0, busy0, dtack0, wrl0, rdl0, csl0} != 6'b000111) begin
         errors++;
         $display("FAIL reset dut0: got %b, required 000111", {abort0, busy0, dtack0, wrl0, rdl0, csl0});
      end
      checks++;
      if ({abort1, busy1, dtack1, wrl1, rdl1, csl1} != 6'b000111) begin
         errors++;
         $display("FAIL reset dut1: got %b, required 000111", {abort1, busy1, dtack1, wrl1, rdl1, csl1});
      end
      prev[0] = 6'b000111;
      prev[1] = 6'b000111;
      mon_en = 1'b1;
      #1;

      // read, write, abort mid-strobe, back-to-back
      access(0, cyc + 2, 1'b1, 1'b0, 2, f);
      access(0, free_at[0] + 1, 1'b0, 1'b0, 1, f);
      access(0, free_at[0] + 1, 1'b1, 1'b1, 3, f);
      access(0, free_at[0] + 1, 1'b1, 1'b0, 0, f);
      access(0, f + 1, 1'b0, 1'b0, 0, f);

      // reset two edges into the strobe phase
      e = free_at[0] + 1;
      expq[0].push_back(key(e + 3, 0, 0));
      expq[0].push_back(key(e + 3, 4, 1));
      expq[0].push_back(key(e + 4, 1, 0));
      expq[0].push_back(key(e + 6, 0, 1));
      expq[0].push_back(key(e + 6, 1, 1));
      expq[0].push_back(key(e + 6, 4, 0));
      goto(e);
      set_in(0, 1'b1, 1'b1);
      goto(e + 5);
      reset = 1'b1;
      set_sel(0, 1'b0);
      goto(e + 6);
      reset = 1'b0;
      free_at[0] = e + 7;
      if (free_at[1] < e + 7) free_at[1] = e + 7;
      last_ev = e + 7;
      f = e + 6;
      access(0, f + 1, 1'b1, 1'b0, 1, f);

      // randomized traffic on the default-timing instance
      for (int n = 0; n < 30; n++) begin
         gap = $urandom_range(1, 8);
         ab  = ($urandom_range(0, 3) == 0);
         rd  = 1'($urandom_range(0, 1));
         access(0, f + gap, rd, ab,
                ab ? int'($urandom_range(0, S0 + T0 - 1)) : int'($urandom_range(0, 4)), f);
      end

      // long-timing instance: directed read, then random traffic
      access(1, cyc + 2, 1'b1, 1'b0, 1, f);
      for (int n = 0; n < 20; n++) begin
         gap = $urandom_range(1, 8);
         ab  = ($urandom_range(0, 3) == 0);
         rd  = 1'($urandom_range(0, 1));
         access(1, f + gap, rd, ab,
                ab ? int'($urandom_range(0, S1 + T1 - 1)) : int'($urandom_range(0, 4)), f);
      end

      goto(last_ev + 5);
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (expq[i].size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d: %0d events outstanding, required 0", i, expq[i].size());
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
